// File: rtl/tw_half.sv
// Inverse-path twiddle scaler: divides complex samples by 2^SHIFT with round-half-up,
// behind a 2-stage valid/ready pipeline with frame marking and an inexact-sample counter.
module tw_half #(
    parameter int WIDTH     = 32,
    parameter int SHIFT     = 1,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] j_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] j_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] inexact_cnt,
    input  logic             cnt_clr
);

    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FW-1:0] LAST_BEAT = FW'(FRAME_LEN - 1);
    localparam logic signed [WIDTH:0] HALF = (WIDTH + 1)'(1) << (SHIFT - 1);

    // One extra bit of headroom keeps the rounding add from wrapping at the positive limit.
    function automatic logic [WIDTH-1:0] round_shift(input logic [WIDTH-1:0] x);
        logic signed [WIDTH:0] sum;
        sum = $signed({x[WIDTH-1], x}) + HALF;
        sum = sum >>> SHIFT;
        return sum[WIDTH-1:0];
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_re;
    logic [WIDTH-1:0] s1_im;
    logic             s1_inexact;
    logic             s2_inexact;
    logic [FW-1:0]    frame_cnt;
    logic             s2_load;
    logic             in_fire;
    logic             out_fire;
    logic             sample_inexact;

    assign s2_load        = !out_valid || out_ready;
    assign in_ready       = !rst && (!s1_valid || s2_load);
    assign in_fire        = in_valid && in_ready;
    assign out_fire       = out_valid && out_ready;
    assign out_last       = out_valid && (frame_cnt == LAST_BEAT);
    assign sample_inexact = (|in[SHIFT-1:0]) || (|j_in[SHIFT-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_re      <= '0;
            s1_im      <= '0;
            s1_inexact <= 1'b0;
        end else if (in_fire) begin
            s1_valid   <= 1'b1;
            s1_re      <= round_shift(in);
            s1_im      <= round_shift(j_in);
            s1_inexact <= sample_inexact;
        end else if (s2_load) begin
            s1_valid   <= 1'b0;
        end
    end

    // Output data only changes when a real beat moves in, so a stalled beat stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out        <= '0;
            j_out      <= '0;
            s2_inexact <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out        <= s1_re;
                j_out      <= s1_im;
                s2_inexact <= s1_inexact;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (out_fire) begin
            frame_cnt <= (frame_cnt == LAST_BEAT) ? '0 : frame_cnt + FW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inexact_cnt <= '0;
        end else if (cnt_clr) begin
            inexact_cnt <= '0;
        end else if (out_fire && s2_inexact && (inexact_cnt != '1)) begin
            inexact_cnt <= inexact_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tw_half.sv
// Scoreboard bench for tw_half: expected beats queued at input handshake, compared at output handshake.
module tb_tw_half;

    localparam int SHIFT     = 1;
    localparam int FRAME_LEN = 8;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        bit          inx;
        int          cyc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] re_in, im_in;
    logic        in_valid, out_ready, cnt_clr;
    logic        in_ready, out_valid, out_last;
    logic [31:0] re_out, im_out;
    logic [15:0] inexact_cnt;

    logic        in_ready2, out_valid2, out_last2;
    logic [31:0] re_out2, im_out2;
    logic [1:0]  cnt2;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   exp_frame = 0;
    int   exp_cnt = 0;
    int   exp_cnt2 = 0;
    bit   check_lat = 0;
    bit   mon_inx;

    tw_half #(.WIDTH(32), .SHIFT(SHIFT), .FRAME_LEN(FRAME_LEN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in(re_in), .j_in(im_in), .in_valid(in_valid),
        .in_ready(in_ready), .out(re_out), .j_out(im_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .inexact_cnt(inexact_cnt),
        .cnt_clr(cnt_clr)
    );

    // Narrow-counter twin fed identically, used only for the saturation checks.
    tw_half #(.WIDTH(32), .SHIFT(SHIFT), .FRAME_LEN(FRAME_LEN), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in(re_in), .j_in(im_in), .in_valid(in_valid),
        .in_ready(in_ready2), .out(re_out2), .j_out(im_out2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_last(out_last2), .inexact_cnt(cnt2),
        .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_round(input logic [31:0] x);
        longint v, d, n, r;
        v = longint'($signed(x));
        d = longint'(1) << SHIFT;
        n = v + d / 2;
        if (n >= 0) r = n / d;
        else        r = -((-n + d - 1) / d);
        return r[31:0];
    endfunction

    function automatic bit model_inexact(input logic [31:0] a, input logic [31:0] b);
        longint d;
        d = longint'(1) << SHIFT;
        return ((longint'($signed(a)) % d) != 0) || ((longint'($signed(b)) % d) != 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit want_ready);
        int n;
        exp_t e;
        n = 0;
        re_in = a;
        im_in = b;
        in_valid = 1'b1;
        @(negedge clk);
        if (want_ready) checkOutput("in_ready_stream", in_ready, 1);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", in_ready, 1);
        end else begin
            e.re  = model_round(a);
            e.im  = model_round(b);
            e.inx = model_inexact(a, b);
            e.cyc = cyc + 1;
            e.lat = check_lat;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) checkOutput("drain_timeout", q.size(), 0);
    endtask

    // Output monitor and counter model, sampled mid-cycle ahead of the edge it predicts.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_frame = 0;
            exp_cnt = 0;
            exp_cnt2 = 0;
        end else begin
            mon_inx = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checkOutput("spurious_beat", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    mon_inx = mon_e.inx;
                    checkOutput("out", re_out, mon_e.re);
                    checkOutput("j_out", im_out, mon_e.im);
                    checkOutput("out_last", out_last, (exp_frame == FRAME_LEN - 1));
                    if (mon_e.lat) checkOutput("latency", cyc, mon_e.cyc + 1);
                end
                exp_frame = (exp_frame == FRAME_LEN - 1) ? 0 : exp_frame + 1;
            end
            if (cnt_clr) begin
                exp_cnt = 0;
                exp_cnt2 = 0;
            end else if (mon_inx) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        re_in = '0;
        im_in = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out", re_out, 0);
        checkOutput("rst_j_out", im_out, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_cnt", inexact_cnt, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Arithmetic and latency
        out_ready = 1'b1;
        check_lat = 1'b1;
        applyStimulus(32'd7, -32'sd7, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        applyStimulus(-32'sd1, 32'd1, 1'b0);
        applyStimulus(32'd0, -32'sd6, 1'b0);
        drain();
        checkOutput("round_pos_tie", model_round(32'd7), 32'd4);
        checkOutput("round_neg_tie", model_round(-32'sd7), -32'sd3);

        // Throughput: back-to-back beats
        for (int i = 0; i < 20; i++)
            applyStimulus($urandom, $urandom, 1'b1);
        drain();

        // Backpressure
        check_lat = 1'b0;
        out_ready = 1'b0;
        applyStimulus(32'd101, 32'd1, 1'b0);
        applyStimulus(32'd102, 32'd2, 1'b0);
        re_in = 32'd103;
        im_in = 32'd3;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_hold_out", re_out, model_round(32'd101));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(32'd103, 32'd3, 1'b0);
        applyStimulus(32'd104, 32'd4, 1'b0);
        drain();

        // Framing: realign to a frame boundary, then two full frames
        check_lat = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(i, i, 1'b0);
        drain();
        for (int i = 0; i < 16; i++) applyStimulus(32'd200 + i, 32'd300 - i, 1'b1);
        drain();
        for (int i = 0; i < 7; i++) applyStimulus(32'd40 + i, 32'd0, 1'b0);
        drain();
        check_lat = 1'b0;
        out_ready = 1'b0;
        applyStimulus(32'd48, 32'd0, 1'b0);
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_last_valid", out_valid, 1);
            checkOutput("stall_last", out_last, 1);
        end
        @(posedge clk);
        #1;
        drain();

        // Inexact counter
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checkOutput("clr_cnt", inexact_cnt, 0);
        checkOutput("clr_cnt2", cnt2, 0);
        applyStimulus(32'd7, 32'd0, 1'b0);
        applyStimulus(32'd6, 32'd2, 1'b0);
        applyStimulus(32'd4, 32'd5, 1'b0);
        applyStimulus(32'd8, 32'd8, 1'b0);
        drain();
        checkOutput("inexact_2", inexact_cnt, 2);
        checkOutput("inexact_model", inexact_cnt, exp_cnt);
        out_ready = 1'b0;
        applyStimulus(32'd3, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checkOutput("clr_beats_inc", inexact_cnt, 0);
        checkOutput("clr_beats_inc2", cnt2, 0);
        applyStimulus(32'd1, 32'd0, 1'b0);
        applyStimulus(32'd3, 32'd3, 1'b0);
        applyStimulus(32'd5, 32'd0, 1'b0);
        applyStimulus(32'd0, 32'd9, 1'b0);
        applyStimulus(-32'sd1, -32'sd1, 1'b0);
        drain();
        checkOutput("inexact_5", inexact_cnt, 5);
        checkOutput("sat_cnt2", cnt2, 3);
        checkOutput("sat_cnt2_model", cnt2, exp_cnt2);

        // Reset with two beats in flight
        check_lat = 1'b1;
        applyStimulus(32'd11, 32'd12, 1'b0);
        applyStimulus(32'd13, 32'd14, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out", re_out, 0);
        checkOutput("midrst_j_out", im_out, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_release_ready", in_ready, 1);
        checkOutput("midrst_cnt", inexact_cnt, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) applyStimulus(32'd500 + i, -32'sd500 - i, 1'b1);
        drain();

        checkOutput("leftover", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
